// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared types and constants for the RC4 key-search core.
//                Sequencer state encoding and S-memory grant codes, which are
//                also used by the decrypt engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

    // Sequencer state encoding
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INIT_REQ  = 4'd1,
        ST_INIT_WAIT = 4'd2,
        ST_SHUF_REQ  = 4'd3,
        ST_SHUF_WAIT = 4'd4,
        ST_DEC_REQ   = 4'd5,
        ST_DEC_WAIT  = 4'd6,
        ST_FOUND     = 4'd7,
        ST_EXHAUSTED = 4'd8,
        ST_ABORTED   = 4'd9
    } sched_state_t;

    // S-memory grant codes
    localparam logic [1:0] MSEL_INIT = 2'd0;
    localparam logic [1:0] MSEL_SHUF = 2'd1;
    localparam logic [1:0] MSEL_DEC  = 2'd2;
    localparam logic [1:0] MSEL_IDLE = 2'd3;

    // Grant owned by each sequencer state; terminal and idle states own nothing
    function automatic logic [1:0] msel_of_state(input sched_state_t s);
        logic [1:0] m;
        case (s)
            ST_INIT_REQ, ST_INIT_WAIT: m = MSEL_INIT;
            ST_SHUF_REQ, ST_SHUF_WAIT: m = MSEL_SHUF;
            ST_DEC_REQ,  ST_DEC_WAIT:  m = MSEL_DEC;
            default:                   m = MSEL_IDLE;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_smem_mux.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_smem_mux
//  Description : 3:1 S-memory port mux selected by the current grant. With no
//                engine granted the port is parked at zero with writes off.
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_smem_mux
    import rc4_pkg::*;
(
    input  logic [1:0] i_sel,
    input  logic [7:0] i_init_addr,
    input  logic [7:0] i_init_data,
    input  logic       i_init_wen,
    input  logic [7:0] i_shuf_addr,
    input  logic [7:0] i_shuf_data,
    input  logic       i_shuf_wen,
    input  logic [7:0] i_dec_addr,
    input  logic [7:0] i_dec_data,
    input  logic       i_dec_wen,
    output logic [7:0] o_addr,
    output logic [7:0] o_data,
    output logic       o_wen
);

    // Route the granted engine's request onto the single memory port
    always_comb begin
        o_addr = 8'd0;
        o_data = 8'd0;
        o_wen  = 1'b0;
        case (i_sel)
            MSEL_INIT: begin
                o_addr = i_init_addr;
                o_data = i_init_data;
                o_wen  = i_init_wen;
            end
            MSEL_SHUF: begin
                o_addr = i_shuf_addr;
                o_data = i_shuf_data;
                o_wen  = i_shuf_wen;
            end
            MSEL_DEC: begin
                o_addr = i_dec_addr;
                o_data = i_dec_data;
                o_wen  = i_dec_wen;
            end
            default: begin
                o_addr = 8'd0;
                o_data = 8'd0;
                o_wen  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rc4_search_sched.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_search_sched
//  Description : Key-search sequencer for one RC4 core. Walks candidate keys,
//                runs init -> shuffle -> decrypt for each, arbitrates the
//                S-memory write port and stops on success, exhaustion or an
//                abort from another core.
//  Revision    : 1.0 - initial release
// ============================================================================
module rc4_search_sched
    import rc4_pkg::*;
#(
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_STEP  = KEY_WIDTH'(1),
    parameter logic [KEY_WIDTH-1:0] KEY_LAST  = KEY_WIDTH'(24'h3FFFFF)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_sig,
    input  logic                 other_finished,
    output logic                 init_start,
    output logic                 shuf_start,
    output logic                 dec_start,
    input  logic                 init_finish,
    input  logic                 shuf_finish,
    input  logic                 dec_finish,
    input  logic                 dec_valid,
    input  logic [7:0]           init_addr,
    input  logic [7:0]           init_data,
    input  logic                 init_wen,
    input  logic [7:0]           shuf_addr,
    input  logic [7:0]           shuf_data,
    input  logic                 shuf_wen,
    input  logic [7:0]           dec_addr,
    input  logic [7:0]           dec_data,
    input  logic                 dec_wen,
    output logic [7:0]           s_address,
    output logic [7:0]           s_data,
    output logic                 s_wen,
    output logic [1:0]           memory_sel,
    output logic [KEY_WIDTH-1:0] secret_key,
    output logic                 busy,
    output logic                 finish,
    output logic                 key_found,
    output logic                 key_exhausted
);

    // Any key above this has no legal successor; comparing against it with the
    // pre-increment key keeps the key register from ever wrapping.
    localparam logic [KEY_WIDTH-1:0] c_KEY_LIMIT = KEY_LAST - KEY_STEP;

    sched_state_t         r_state;
    sched_state_t         w_state_d;
    logic [KEY_WIDTH-1:0] r_key;
    logic [KEY_WIDTH-1:0] w_key_d;
    logic [1:0]           r_msel;
    logic                 r_init_start, r_shuf_start, r_dec_start;
    logic                 r_busy, r_finish, r_found, r_exhausted;

    // Next-state and next-key selection; abort is checked before phase
    // completion except for a simultaneous own success, which wins
    always_comb begin
        w_state_d = r_state;
        w_key_d   = r_key;
        case (r_state)
            ST_IDLE: begin
                if (start_sig) begin
                    w_state_d = other_finished ? ST_ABORTED : ST_INIT_REQ;
                end
            end
            ST_INIT_REQ:  w_state_d = other_finished ? ST_ABORTED : ST_INIT_WAIT;
            ST_INIT_WAIT: begin
                if (other_finished)   w_state_d = ST_ABORTED;
                else if (init_finish) w_state_d = ST_SHUF_REQ;
            end
            ST_SHUF_REQ:  w_state_d = other_finished ? ST_ABORTED : ST_SHUF_WAIT;
            ST_SHUF_WAIT: begin
                if (other_finished)   w_state_d = ST_ABORTED;
                else if (shuf_finish) w_state_d = ST_DEC_REQ;
            end
            ST_DEC_REQ:   w_state_d = other_finished ? ST_ABORTED : ST_DEC_WAIT;
            ST_DEC_WAIT: begin
                if (dec_finish && dec_valid) begin
                    w_state_d = ST_FOUND;
                end else if (other_finished) begin
                    w_state_d = ST_ABORTED;
                end else if (dec_finish) begin
                    if (r_key > c_KEY_LIMIT) begin
                        w_state_d = ST_EXHAUSTED;
                    end else begin
                        w_key_d   = r_key + KEY_STEP;
                        w_state_d = ST_INIT_REQ;
                    end
                end
            end
            default: w_state_d = r_state;  // terminal states are sticky
        endcase
    end

    // State, key and every status output registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_key        <= KEY_START;
            r_msel       <= MSEL_IDLE;
            r_init_start <= 1'b0;
            r_shuf_start <= 1'b0;
            r_dec_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_finish     <= 1'b0;
            r_found      <= 1'b0;
            r_exhausted  <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_key        <= w_key_d;
            r_msel       <= msel_of_state(w_state_d);
            r_init_start <= (w_state_d == ST_INIT_REQ);
            r_shuf_start <= (w_state_d == ST_SHUF_REQ);
            r_dec_start  <= (w_state_d == ST_DEC_REQ);
            r_busy       <= (w_state_d inside {ST_INIT_REQ, ST_INIT_WAIT, ST_SHUF_REQ,
                                               ST_SHUF_WAIT, ST_DEC_REQ, ST_DEC_WAIT});
            r_finish     <= (w_state_d inside {ST_FOUND, ST_EXHAUSTED, ST_ABORTED});
            r_found      <= (w_state_d == ST_FOUND);
            r_exhausted  <= (w_state_d == ST_EXHAUSTED);
        end
    end

    rc4_smem_mux u_smem_mux (
        .i_sel       (r_msel),
        .i_init_addr (init_addr),
        .i_init_data (init_data),
        .i_init_wen  (init_wen),
        .i_shuf_addr (shuf_addr),
        .i_shuf_data (shuf_data),
        .i_shuf_wen  (shuf_wen),
        .i_dec_addr  (dec_addr),
        .i_dec_data  (dec_data),
        .i_dec_wen   (dec_wen),
        .o_addr      (s_address),
        .o_data      (s_data),
        .o_wen       (s_wen)
    );

    assign init_start    = r_init_start;
    assign shuf_start    = r_shuf_start;
    assign dec_start     = r_dec_start;
    assign memory_sel    = r_msel;
    assign secret_key    = r_key;
    assign busy          = r_busy;
    assign finish        = r_finish;
    assign key_found     = r_found;
    assign key_exhausted = r_exhausted;

endmodule
`default_nettype wire

// File: tb/tb_rc4_search_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rc4_search_sched
//  Description : Scoreboard bench for rc4_search_sched. Instance 0 uses keys
//                0..3 step 1, instance 1 uses keys 1..6 step 2. Engines answer
//                every start with a finish five cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rc4_search_sched;

    localparam int K_INIT = 0, K_SHUF = 1, K_DEC = 2, K_FOUND = 3, K_EXH = 4, K_ABORT = 5;

    typedef struct {
        int          kind;
        logic [23:0] key;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset [2], start_sig [2], other_fin [2];
    logic        init_start [2], shuf_start [2], dec_start [2];
    logic        init_finish [2], shuf_finish [2], dec_finish [2], dec_valid [2];
    logic [7:0]  init_addr [2], init_data [2], shuf_addr [2], shuf_data [2], dec_addr [2], dec_data [2];
    logic        init_wen [2], shuf_wen [2], dec_wen [2];
    logic [7:0]  s_address [2], s_data [2];
    logic        s_wen [2], busy [2], finish [2], key_found [2], key_exhausted [2];
    logic [1:0]  memory_sel [2];
    logic [23:0] secret_key [2];

    logic [23:0] valid_key [2];
    int          eng_cnt [2], eng_ph [2];
    ev_t         exp_q0 [$];
    ev_t         exp_q1 [$];
    int          n_vec = 0;
    int          n_miss = 0;

    rc4_search_sched #(.KEY_WIDTH(24), .KEY_START(24'd0), .KEY_STEP(24'd1), .KEY_LAST(24'd3)) dut0 (
        .clk(clk), .reset(reset[0]), .start_sig(start_sig[0]), .other_finished(other_fin[0]),
        .init_start(init_start[0]), .shuf_start(shuf_start[0]), .dec_start(dec_start[0]),
        .init_finish(init_finish[0]), .shuf_finish(shuf_finish[0]), .dec_finish(dec_finish[0]),
        .dec_valid(dec_valid[0]),
        .init_addr(init_addr[0]), .init_data(init_data[0]), .init_wen(init_wen[0]),
        .shuf_addr(shuf_addr[0]), .shuf_data(shuf_data[0]), .shuf_wen(shuf_wen[0]),
        .dec_addr(dec_addr[0]), .dec_data(dec_data[0]), .dec_wen(dec_wen[0]),
        .s_address(s_address[0]), .s_data(s_data[0]), .s_wen(s_wen[0]),
        .memory_sel(memory_sel[0]), .secret_key(secret_key[0]), .busy(busy[0]),
        .finish(finish[0]), .key_found(key_found[0]), .key_exhausted(key_exhausted[0])
    );

    rc4_search_sched #(.KEY_WIDTH(24), .KEY_START(24'd1), .KEY_STEP(24'd2), .KEY_LAST(24'd6)) dut1 (
        .clk(clk), .reset(reset[1]), .start_sig(start_sig[1]), .other_finished(other_fin[1]),
        .init_start(init_start[1]), .shuf_start(shuf_start[1]), .dec_start(dec_start[1]),
        .init_finish(init_finish[1]), .shuf_finish(shuf_finish[1]), .dec_finish(dec_finish[1]),
        .dec_valid(dec_valid[1]),
        .init_addr(init_addr[1]), .init_data(init_data[1]), .init_wen(init_wen[1]),
        .shuf_addr(shuf_addr[1]), .shuf_data(shuf_data[1]), .shuf_wen(shuf_wen[1]),
        .dec_addr(dec_addr[1]), .dec_data(dec_data[1]), .dec_wen(dec_wen[1]),
        .s_address(s_address[1]), .s_data(s_data[1]), .s_wen(s_wen[1]),
        .memory_sel(memory_sel[1]), .secret_key(secret_key[1]), .busy(busy[1]),
        .finish(finish[1]), .key_found(key_found[1]), .key_exhausted(key_exhausted[1])
    );

    // Engine models: finish pulse five cycles after each start
    initial begin
        for (int i = 0; i < 2; i++) begin
            init_finish[i] = 1'b0; shuf_finish[i] = 1'b0; dec_finish[i] = 1'b0; dec_valid[i] = 1'b0;
            eng_cnt[i] = 0; eng_ph[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                init_finish[i] = 1'b0; shuf_finish[i] = 1'b0; dec_finish[i] = 1'b0; dec_valid[i] = 1'b0;
                if (eng_cnt[i] > 0) begin
                    eng_cnt[i] = eng_cnt[i] - 1;
                    if (eng_cnt[i] == 0) begin
                        case (eng_ph[i])
                            0: init_finish[i] = 1'b1;
                            1: shuf_finish[i] = 1'b1;
                            default: begin
                                dec_finish[i] = 1'b1;
                                dec_valid[i]  = (secret_key[i] == valid_key[i]);
                            end
                        endcase
                    end
                end
                if (init_start[i]) begin eng_ph[i] = 0; eng_cnt[i] = 5; end
                if (shuf_start[i]) begin eng_ph[i] = 1; eng_cnt[i] = 5; end
                if (dec_start[i])  begin eng_ph[i] = 2; eng_cnt[i] = 5; end
            end
        end
    end

    task automatic push(input int idx, input int kind, input logic [23:0] key);
        ev_t e;
        e.kind = kind;
        e.key  = key;
        if (idx == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
    endtask

    task automatic push_key(input int idx, input logic [23:0] key);
        push(idx, K_INIT, key);
        push(idx, K_SHUF, key);
        push(idx, K_DEC, key);
    endtask

    task automatic observe(input int idx, input int kind);
        ev_t         e;
        logic [23:0] k;
        int          qsz;
        k   = secret_key[idx];
        qsz = (idx == 0) ? exp_q0.size() : exp_q1.size();
        n_vec++;
        if (qsz == 0) begin
            n_miss++;
            $display("FAIL unexpected_event dut%0d: got kind %0d key %0d, required no event", idx, kind, k);
        end else begin
            e = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (e.kind != kind || e.key != k) begin
                n_miss++;
                $display("FAIL event_order dut%0d: got kind %0d key %0d, required kind %0d key %0d",
                         idx, kind, k, e.kind, e.key);
            end
        end
    endtask

    // Monitor: every start pulse cycle and every rising finish is an event
    logic fin_prev [2];
    initial begin
        fin_prev[0] = 1'b0;
        fin_prev[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (init_start[i] === 1'b1) observe(i, K_INIT);
                if (shuf_start[i] === 1'b1) observe(i, K_SHUF);
                if (dec_start[i]  === 1'b1) observe(i, K_DEC);
                if (finish[i] === 1'b1 && fin_prev[i] !== 1'b1)
                    observe(i, key_found[i] ? K_FOUND : (key_exhausted[i] ? K_EXH : K_ABORT));
                fin_prev[i] = finish[i];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input int idx);
        start_sig[idx] = 1'b1;
        @(negedge clk);
        start_sig[idx] = 1'b0;
    endtask

    task automatic do_reset(input int idx);
        reset[idx] = 1'b1;
        tick(2);
        reset[idx] = 1'b0;
    endtask

    task automatic wait_fin(input int idx, input int max);
        int c = 0;
        while (finish[idx] !== 1'b1 && c < max) begin
            @(negedge clk);
            c++;
        end
        n_vec++;
        if (finish[idx] !== 1'b1) begin
            n_miss++;
            $display("FAIL finish_timeout dut%0d: got finish=%0b after %0d cycles, required 1", idx, finish[idx], c);
        end
    endtask

    task automatic q_empty(input string name, input int idx);
        chk(name, (idx == 0) ? exp_q0.size() : exp_q1.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1; start_sig[i] = 1'b0; other_fin[i] = 1'b0;
            init_addr[i] = 8'd0; init_data[i] = 8'd0; init_wen[i] = 1'b0;
            shuf_addr[i] = 8'd0; shuf_data[i] = 8'd0; shuf_wen[i] = 1'b0;
            dec_addr[i]  = 8'd0; dec_data[i]  = 8'd0; dec_wen[i]  = 1'b0;
            valid_key[i] = 24'hFFFFFF;
        end
        tick(3);
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        // Reset state
        chk("rst_busy", busy[0], 0);
        chk("rst_finish", finish[0], 0);
        chk("rst_found", key_found[0], 0);
        chk("rst_exh", key_exhausted[0], 0);
        chk("rst_msel", memory_sel[0], 3);
        chk("rst_swen", s_wen[0], 0);
        chk("rst_saddr", s_address[0], 0);
        chk("rst_sdata", s_data[0], 0);
        chk("rst_key", secret_key[0], 0);
        chk("rst_init_start", init_start[0], 0);
        chk("rst_key_dut1", secret_key[1], 1);

        // Search hits at key 2; grant check while INIT_WAIT
        valid_key[0] = 24'd2;
        push_key(0, 0); push_key(0, 1); push_key(0, 2); push(0, K_FOUND, 2);
        pulse_start(0);
        chk("start_latency", init_start[0], 1);
        @(negedge clk);
        init_addr[0] = 8'h11; init_data[0] = 8'h22; init_wen[0] = 1'b0;
        shuf_addr[0] = 8'h33; shuf_data[0] = 8'h44; shuf_wen[0] = 1'b1;
        #1;
        chk("grant_msel", memory_sel[0], 0);
        chk("grant_swen_blocked", s_wen[0], 0);
        chk("grant_saddr", s_address[0], 8'h11);
        chk("grant_sdata", s_data[0], 8'h22);
        init_wen[0] = 1'b1;
        #1;
        chk("grant_swen_init", s_wen[0], 1);
        init_wen[0] = 1'b0; init_addr[0] = 8'd0; init_data[0] = 8'd0;
        shuf_wen[0] = 1'b0; shuf_addr[0] = 8'd0; shuf_data[0] = 8'd0;
        wait_fin(0, 300);
        chk("found_flag", key_found[0], 1);
        chk("found_key", secret_key[0], 2);
        chk("found_exh", key_exhausted[0], 0);
        chk("found_busy", busy[0], 0);
        chk("found_msel", memory_sel[0], 3);
        q_empty("found_events", 0);
        other_fin[0] = 1'b1;
        pulse_start(0);
        other_fin[0] = 1'b0;
        tick(10);
        chk("found_sticky", key_found[0], 1);
        chk("found_sticky_key", secret_key[0], 2);

        // Never valid: keys 0..3 once each, then exhausted without a wrap
        do_reset(0);
        chk("rst2_key", secret_key[0], 0);
        chk("rst2_finish", finish[0], 0);
        valid_key[0] = 24'hFFFFFF;
        for (int k = 0; k < 4; k++) push_key(0, 24'(k));
        push(0, K_EXH, 3);
        pulse_start(0);
        wait_fin(0, 400);
        chk("exh_flag", key_exhausted[0], 1);
        chk("exh_found", key_found[0], 0);
        chk("exh_key", secret_key[0], 3);
        tick(20);
        chk("exh_key_hold", secret_key[0], 3);
        q_empty("exh_events", 0);

        // Instance 1: start 1 step 2 last 6 -> keys 1,3,5
        push_key(1, 1); push_key(1, 3); push_key(1, 5); push(1, K_EXH, 5);
        pulse_start(1);
        wait_fin(1, 400);
        chk("step2_exh", key_exhausted[1], 1);
        chk("step2_key", secret_key[1], 5);
        q_empty("step2_events", 1);

        // Abort during SHUF_WAIT at key 1
        do_reset(0);
        valid_key[0] = 24'hFFFFFF;
        push_key(0, 0); push(0, K_INIT, 1); push(0, K_SHUF, 1); push(0, K_ABORT, 1);
        pulse_start(0);
        begin
            int c = 0;
            while (!(shuf_start[0] === 1'b1 && secret_key[0] == 24'd1) && c < 300) begin
                @(negedge clk);
                c++;
            end
        end
        @(negedge clk);
        other_fin[0] = 1'b1;
        shuf_wen[0] = 1'b1; shuf_addr[0] = 8'h55; shuf_data[0] = 8'h66;
        @(negedge clk);
        other_fin[0] = 1'b0;
        #1;
        chk("abort_finish", finish[0], 1);
        chk("abort_found", key_found[0], 0);
        chk("abort_exh", key_exhausted[0], 0);
        chk("abort_msel", memory_sel[0], 3);
        chk("abort_swen", s_wen[0], 0);
        chk("abort_saddr", s_address[0], 0);
        chk("abort_key", secret_key[0], 1);
        shuf_wen[0] = 1'b0; shuf_addr[0] = 8'd0; shuf_data[0] = 8'd0;
        pulse_start(0);
        tick(30);
        chk("abort_sticky_busy", busy[0], 0);
        chk("abort_sticky_finish", finish[0], 1);
        q_empty("abort_events", 0);

        // Own success in the same cycle as another core's abort
        do_reset(0);
        valid_key[0] = 24'd0;
        push_key(0, 0); push(0, K_FOUND, 0);
        pulse_start(0);
        begin
            int c = 0;
            while (dec_start[0] !== 1'b1 && c < 200) begin
                @(negedge clk);
                c++;
            end
        end
        repeat (5) @(negedge clk);
        #1;
        other_fin[0] = 1'b1;
        @(negedge clk);
        other_fin[0] = 1'b0;
        #1;
        chk("race_found", key_found[0], 1);
        chk("race_finish", finish[0], 1);
        chk("race_key", secret_key[0], 0);
        q_empty("race_events", 0);

        // Mid-search reset, then a fresh search from key 0
        do_reset(0);
        valid_key[0] = 24'd1;
        push_key(0, 0); push(0, K_INIT, 1);
        pulse_start(0);
        begin
            int c = 0;
            while (!(init_start[0] === 1'b1 && secret_key[0] == 24'd1) && c < 200) begin
                @(negedge clk);
                c++;
            end
        end
        reset[0] = 1'b1;
        @(negedge clk);
        reset[0] = 1'b0;
        chk("midrst_busy", busy[0], 0);
        chk("midrst_key", secret_key[0], 0);
        chk("midrst_init_start", init_start[0], 0);
        chk("midrst_msel", memory_sel[0], 3);
        tick(12);
        chk("midrst_idle_busy", busy[0], 0);
        chk("midrst_idle_finish", finish[0], 0);
        push_key(0, 0); push_key(0, 1); push(0, K_FOUND, 1);
        pulse_start(0);
        wait_fin(0, 300);
        chk("midrst_found", key_found[0], 1);
        chk("midrst_found_key", secret_key[0], 1);
        q_empty("midrst_events", 0);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
